// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie break and a
// per-grant burst limit. Master 0 is the VGA frame reader, which holds cyc
// permanently; the burst limit ensures the frame-buffer writer on master 1
// still gets slots. Grants change only on an ack edge or when the owner
// drops cyc, and every release is followed by exactly one idle cycle.
module wshb_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int ADR_W     = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [31:0]      m0_dat_ms,
    input  logic [3:0]       m0_sel,
    output logic             m0_ack,
    output logic [31:0]      m0_dat_sm,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [31:0]      m1_dat_ms,
    input  logic [3:0]       m1_sel,
    output logic             m1_ack,
    output logic [31:0]      m1_dat_sm,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [31:0]      s_dat_ms,
    output logic [3:0]       s_sel,
    input  logic             s_ack,
    input  logic [31:0]      s_dat_sm,

    output logic [1:0]       gnt
);

    // Counter wide enough to hold MAX_BURST itself so it can saturate there.
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_REL = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [1:0] req_w;
    logic [1:0] cyc_w;
    logic [1:0] ack_w;

    // Per-master views so the grant logic can treat both masters uniformly.
    assign req_w[0] = m0_cyc & m0_stb;
    assign req_w[1] = m1_cyc & m1_stb;
    assign cyc_w[0] = m0_cyc;
    assign cyc_w[1] = m1_cyc;

    // Limit reached on this ack: hand over if the other master wants the bus.
    // Using >= also covers the saturated case where the release was deferred
    // because the other master was idle at the limit.
    logic limit_ack_w;
    assign limit_ack_w = s_ack && (burst_cnt_q >= CNT_REL);

    // State, round-robin memory and burst counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic: arbitration from IDLE, release from a grant.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                // On a tie, last_q=1 means master 1 went last, so master 0 wins.
                if (req_w[0] && (!req_w[1] || last_q)) begin
                    state_d     = G0;
                    last_d      = 1'b0;
                    burst_cnt_d = '0;
                end else if (req_w[1]) begin
                    state_d     = G1;
                    last_d      = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            G0: begin
                if (s_ack && (burst_cnt_q != CNT_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!cyc_w[0] || (limit_ack_w && req_w[1])) begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (s_ack && (burst_cnt_q != CNT_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!cyc_w[1] || (limit_ack_w && req_w[0])) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: grant decode and combinational master-to-slave mux.
    always_comb begin
        gnt      = 2'b00;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = 4'h0;
        unique case (state_q)
            G0: begin
                gnt      = 2'b01;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
            end
            G1: begin
                gnt      = 2'b10;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
            end
            default: begin
                gnt = 2'b00;
            end
        endcase
    end

    // Ack is steered only to the granted master; read data is broadcast.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_w[gi] = s_ack & gnt[gi];
    end

    assign m0_ack    = ack_w[0];
    assign m1_ack    = ack_w[1];
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

endmodule

// File: doc/wshb_arbiter.md
# wshb_arbiter

Two-master, one-slave Wishbone arbiter that shares the SDRAM controller port between the VGA frame reader and a frame-buffer writer (pattern generator or pixel writer). It sits between the masters and the SDRAM slave in the system clock domain. It does round-robin arbitration with a burst limit, so the VGA reader, which keeps `cyc` high permanently, cannot starve the writer.

## Interface

Parameters:
- `MAX_BURST`, default 64: number of acknowledged transfers after which the current grant is withdrawn if the other master is requesting; range 1..1023.
- `ADR_W`, default 32: address width.

Ports:
- `clk`  in  1  system (Wishbone) clock.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 (VGA reader) cycle, strobe and write enable.
- `m0_adr`  in  ADR_W  master 0 byte address.
- `m0_dat_ms`  in  32  master 0 write data.
- `m0_sel`  in  4  master 0 byte selects.
- `m0_ack`  out  1  acknowledge to master 0.
- `m0_dat_sm`  out  32  read data to master 0.
- `m1_*`  same set as master 0, for master 1 (writer).
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to the SDRAM slave.
- `s_adr`  out  ADR_W  to the SDRAM slave.
- `s_dat_ms`  out  32  to the SDRAM slave.
- `s_sel`  out  4  to the SDRAM slave.
- `s_ack`  in  1  slave acknowledge.
- `s_dat_sm`  in  32  slave read data.
- `gnt`  out  2  one-hot current grant; 2'b00 when idle.

## Operation

- The request of master i is `mi_cyc & mi_stb`.
- FSM states:
  - IDLE: `gnt`=00.
  - G0: `gnt`=01.
  - G1: `gnt`=10.
- IDLE transitions:
  - Only one master requesting: go to that master's state.
  - Both requesting: grant the master that was not granted last (`last` register, reset value 1, so master 0 wins the first tie).
  - No request: stay in IDLE.
- Gi transitions:
  - Go to IDLE when `mi_cyc`=0, or on forced release.
  - On entry, set `last`=i and clear `burst_cnt`.
- Burst counter:
  - `burst_cnt` (`$clog2(MAX_BURST+1)` bits) increments on each `s_ack` in Gi.
  - It saturates at MAX_BURST.
- Forced release: when `s_ack` is high, `burst_cnt`==MAX_BURST-1 and the other master is requesting, go to IDLE on the next edge.
  - The release happens only on an ack edge, so no transfer is ever cut mid-flight.
  - If the other master is not requesting, the grant stays and the counter stays saturated. A release then triggers on the first later `s_ack` at which the other master is requesting.
- Slave-side mux:
  - In Gi: `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_dat_ms` and `s_sel` are the combinational copies of master i's signals.
  - In IDLE: `s_cyc`, `s_stb`, `s_we` and `s_sel` are 0; `s_adr` and `s_dat_ms` are don't-care, driven as 0.
- Ack routing:
  - `mi_ack` = `s_ack & gnt[i]` (combinational).
  - `m0_dat_sm` and `m1_dat_sm` both equal `s_dat_sm`.
  - An ungranted master never sees an ack.

## Timing

- Reset (async assert, sync release):
  - State = IDLE, `gnt`=00, `last`=1, `burst_cnt`=0.
  - All `s_*` outputs = 0; `m0_ack` and `m1_ack` = 0.
- Grant latency: a request sampled at edge N gives `gnt` at edge N+1, and the slave sees `s_cyc`/`s_stb` in the cycle after edge N+1.
- After any release there is always exactly one IDLE cycle. This is the minimum gap between two grants, and `s_cyc` is 0 during it.
- Master-to-slave and `s_ack`-to-`mi_ack` paths are purely combinational, with zero added latency inside a grant.
- If reset is asserted mid-transfer, `s_cyc`/`s_stb` drop immediately. Masters must tolerate a lost ack: the VGA reader re-issues, because its address counter advances only on ack.
- Both masters dropping `cyc` on the same edge: return to IDLE; `last` is unchanged.

## Test plan

- Only m0 requests, slave acks every cycle:
  - `gnt`=01 one cycle after the request.
  - 100 acks reach `m0_ack`; `m1_ack` stays 0.
  - `gnt` does not drop at MAX_BURST=64, because m1 is idle.
- m0 and m1 request in the same cycle after reset:
  - m0 is granted first.
  - After m0 drops `cyc`: one IDLE cycle, then `gnt`=10.
- m0 holds `cyc`/`stb` permanently, m1 requests at cycle 10, MAX_BURST=4, slave acks every cycle:
  - After m0's 4th ack: IDLE for 1 cycle, then G1.
  - After m1 drops `cyc`: IDLE, then G0 again.
- Write through m1 (`adr`=0x100, data 0xDEADBEEF, `sel`=4'hF):
  - `s_*` signals match exactly while `gnt`=10.
  - A read by m0 at 0x100 returns 0xDEADBEEF on `m0_dat_sm`.
- Assert `rst` asynchronously (mid-clock) during G1 with a pending stb:
  - `s_cyc`, `s_stb` and `gnt` are 0 before the next edge.
  - After release, the first tie goes to m0.
- Slave with 3-cycle ack latency, m1 requesting throughout:
  - The forced release from m0 never occurs while `s_stb` is high without an ack.
  - The `burst_cnt` trace matches the number of acks.
